// File: rtl/hangman_guess_engine.sv
// ============================================================================
// Module   : hangman_guess_engine
// Purpose  : Debounces the guess button and judges 5-bit letter guesses
//            against a fixed 4-letter secret word. Drives the display codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hangman_guess_engine #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          START_SCORE     = 10,
    parameter logic [19:0] WORD            = {5'd3, 5'd0, 5'd4, 5'd1}
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnR,
    input  logic [7:0] sw,
    output logic [4:0] slot0,
    output logic [4:0] slot1,
    output logic [4:0] slot2,
    output logic [4:0] slot3,
    output logic [6:0] score,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic       hit,
    output logic       miss,
    output logic       dup,
    output logic       err,
    output logic       won,
    output logic       lost
);

    localparam int                 c_CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]         c_START     = 7'(START_SCORE);
    localparam logic [4:0]         c_BLANK     = 5'd31;
    localparam logic [4:0]         c_LAST_CODE = 5'd25;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WON   = 2'd2,
        ST_LOST  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer, debouncer and rising-edge press pulse
    // ------------------------------------------------------------------
    logic               r_sync1;
    logic               r_sync2;
    logic               r_db;
    logic               r_db_d;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btnR;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
        end
    end

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    state_t      r_state,    w_state_nxt;
    logic [4:0]  r_letter,   w_letter_nxt;
    logic [31:0] r_used,     w_used_nxt;
    logic [3:0]  r_revealed, w_rev_nxt;
    logic [6:0]  r_score,    w_score_nxt;
    logic        r_hit,  w_hit_nxt;
    logic        r_miss, w_miss_nxt;
    logic        r_dup,  w_dup_nxt;
    logic        r_err,  w_err_nxt;

    logic [3:0]  w_match;
    logic [4:0]  w_slot [4];
    logic [4:0]  w_sw_letter;
    logic        w_unused_sw;

    assign w_sw_letter = sw[4:0];
    assign w_unused_sw = ^sw[6:5];

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign w_match[gi] = (WORD[gi*5 +: 5] == r_letter);
        assign w_slot[gi]  = r_revealed[gi] ? WORD[gi*5 +: 5] : c_BLANK;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_letter_nxt = r_letter;
        w_used_nxt   = r_used;
        w_rev_nxt    = r_revealed;
        w_score_nxt  = r_score;
        w_hit_nxt    = 1'b0;
        w_miss_nxt   = 1'b0;
        w_dup_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (r_press) begin
                    if (w_sw_letter > c_LAST_CODE) begin
                        w_err_nxt = 1'b1;
                    end else if (r_used[w_sw_letter]) begin
                        w_dup_nxt = 1'b1;
                    end else begin
                        w_letter_nxt = w_sw_letter;
                        w_state_nxt  = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                w_rev_nxt            = r_revealed | w_match;
                w_used_nxt[r_letter] = 1'b1;
                if (|w_match) begin
                    w_hit_nxt = 1'b1;
                end else begin
                    w_miss_nxt  = 1'b1;
                    w_score_nxt = r_score - 7'd1;
                end
                // End-of-game decision uses the post-update mask and score
                if (&w_rev_nxt) begin
                    w_state_nxt = ST_WON;
                end else if (w_score_nxt == 7'd0) begin
                    w_state_nxt = ST_LOST;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_WON, ST_LOST: begin
                if (r_press && sw[7]) begin
                    w_used_nxt  = '0;
                    w_rev_nxt   = '0;
                    w_score_nxt = c_START;
                    w_state_nxt = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_PLAY;
            r_letter   <= '0;
            r_used     <= '0;
            r_revealed <= '0;
            r_score    <= c_START;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_dup      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_letter   <= w_letter_nxt;
            r_used     <= w_used_nxt;
            r_revealed <= w_rev_nxt;
            r_score    <= w_score_nxt;
            r_hit      <= w_hit_nxt;
            r_miss     <= w_miss_nxt;
            r_dup      <= w_dup_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign slot0      = w_slot[0];
    assign slot1      = w_slot[1];
    assign slot2      = w_slot[2];
    assign slot3      = w_slot[3];
    assign score      = r_score;
    assign score_tens = 4'(r_score / 7'd10);
    assign score_ones = 4'(r_score % 7'd10);
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign dup        = r_dup;
    assign err        = r_err;
    assign won        = (r_state == ST_WON);
    assign lost       = (r_state == ST_LOST);

endmodule

`default_nettype wire

// File: tb/tb_hangman_guess_engine.sv
// ============================================================================
// Module   : tb_hangman_guess_engine
// Purpose  : Directed self-checking bench for hangman_guess_engine ("bead").
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hangman_guess_engine;

    logic       clk;
    logic       rst;
    logic       btnR;
    logic [7:0] sw;
    logic [4:0] slot0, slot1, slot2, slot3;
    logic [6:0] score;
    logic [3:0] score_tens, score_ones;
    logic       hit, miss, dup, err, won, lost;

    int n_cmp;
    int n_err;
    logic any_pulse;

    hangman_guess_engine #(
        .DEBOUNCE_CYCLES (4),
        .START_SCORE     (10),
        .WORD            ({5'd3, 5'd0, 5'd4, 5'd1})
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btnR       (btnR),
        .sw         (sw),
        .slot0      (slot0),
        .slot1      (slot1),
        .slot2      (slot2),
        .slot3      (slot3),
        .score      (score),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .hit        (hit),
        .miss       (miss),
        .dup        (dup),
        .err        (err),
        .won        (won),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise btnR and advance to the cycle after the press pulse (P+1)
    task automatic press_to_p1(input logic [7:0] v);
        sw   = v;
        btnR = 1'b1;
        repeat (8) step();
    endtask

    task automatic release_btn();
        btnR = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        btnR  = 1'b0;
        sw    = 8'h00;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_slots", {slot3, slot2, slot1, slot0}, {5'd31, 5'd31, 5'd31, 5'd31});
        check("rst_score", score, 7'd10);
        check("rst_tens_ones", {score_tens, score_ones}, 8'h10);
        check("rst_won_lost", {won, lost}, 2'b00);
        check("rst_pulses", {hit, miss, dup, err}, 4'b0000);

        // Short glitch must not produce a press
        sw = 8'h04;
        btnR = 1'b1;
        repeat (3) step();
        btnR = 1'b0;
        any_pulse = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            any_pulse = any_pulse | hit | miss | dup | err;
        end
        check("glitch_pulses", any_pulse, 1'b0);
        check("glitch_slots", {slot3, slot2, slot1, slot0}, {5'd31, 5'd31, 5'd31, 5'd31});

        // Guess 'e'
        press_to_p1(8'h04);
        check("e_p1_hit", hit, 1'b0);
        step();
        check("e_p2_pulses", {hit, miss, dup, err}, 4'b1000);
        check("e_slots", {slot3, slot2, slot1, slot0}, {5'd31, 5'd31, 5'd4, 5'd31});
        check("e_score", score, 7'd10);
        step();
        check("e_hit_one_cycle", hit, 1'b0);
        release_btn();

        // Guess 'e' again
        press_to_p1(8'h04);
        check("dup_p1", {hit, miss, dup, err}, 4'b0010);
        step();
        check("dup_p2", {hit, miss, dup, err}, 4'b0000);
        check("dup_score", score, 7'd10);
        release_btn();

        // Invalid code 26
        press_to_p1(8'h1A);
        check("err_p1", {hit, miss, dup, err}, 4'b0001);
        step();
        check("err_score", score, 7'd10);
        release_btn();

        // 'z' is a valid miss
        press_to_p1(8'h19);
        step();
        check("z_pulses", {hit, miss, dup, err}, 4'b0100);
        check("z_score", score, 7'd9);
        check("z_tens_ones", {score_tens, score_ones}, 8'h09);
        release_btn();

        // b, a, d -> win
        press_to_p1(8'h01);
        step();
        check("b_hit", hit, 1'b1);
        check("b_slot0", slot0, 5'd1);
        check("b_won", won, 1'b0);
        release_btn();
        press_to_p1(8'h00);
        step();
        check("a_hit", hit, 1'b1);
        check("a_slot2", slot2, 5'd0);
        release_btn();
        press_to_p1(8'h03);
        step();
        check("d_hit_won", {hit, won, lost}, 3'b110);
        check("won_slots", {slot3, slot2, slot1, slot0}, {5'd3, 5'd0, 5'd4, 5'd1});
        check("won_score", score, 7'd9);
        release_btn();

        // Press without restart qualifier is ignored
        press_to_p1(8'h01);
        check("won_ign_p1", {hit, miss, dup, err}, 4'b0000);
        step();
        check("won_ign_p2", {hit, miss, dup, err, won}, 5'b00001);
        check("won_ign_score", score, 7'd9);
        release_btn();

        // Restart
        press_to_p1(8'h80);
        check("restart_score", score, 7'd10);
        check("restart_slots", {slot3, slot2, slot1, slot0}, {5'd31, 5'd31, 5'd31, 5'd31});
        check("restart_won", won, 1'b0);
        step();
        check("restart_pulses", {hit, miss, dup, err}, 4'b0000);
        release_btn();

        // Ten misses f..o -> lost
        for (int k = 1; k <= 10; k++) begin
            press_to_p1(8'(4 + k));
            step();
            check("miss_pulse", {hit, miss}, 2'b01);
            check("miss_score", score, 32'(10 - k));
            if (k == 5) check("miss5_tens_ones", {score_tens, score_ones}, 8'h05);
            if (k == 9) check("miss9_lost", lost, 1'b0);
            release_btn();
        end
        check("lost_level", {won, lost}, 2'b01);
        check("lost_score", score, 7'd0);

        // Restart out of LOST
        press_to_p1(8'h80);
        check("lost_restart", {score, lost}, {7'd10, 1'b0});
        release_btn();

        // Reset during CHECK of a hit discards it
        press_to_p1(8'h01);
        rst  = 1'b1;
        btnR = 1'b0;
        step();
        check("rstchk_hit", hit, 1'b0);
        check("rstchk_slots", {slot3, slot2, slot1, slot0}, {5'd31, 5'd31, 5'd31, 5'd31});
        check("rstchk_score", score, 7'd10);
        check("rstchk_won_lost", {won, lost}, 2'b00);
        rst = 1'b0;
        any_pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            any_pulse = any_pulse | hit | miss | dup | err;
        end
        check("rstchk_quiet", any_pulse, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
